// File: rtl/vga_fb_pkg.sv
// ----------------------------------------------------------------------------
// vga_fb_pkg
// Shared types and defaults for the framebuffer arbiter slice.
//   fb_addr_t / fb_data_t : default-width framebuffer word address / data
//   owner_e               : owner tag carried alongside an in-flight read
//   FB_STARVE_LIMIT       : default host starvation limit
// ----------------------------------------------------------------------------
package vga_fb_pkg;

  localparam int unsigned FB_ADDR_W       = 16;
  localparam int unsigned FB_DATA_W       = 32;
  localparam int unsigned FB_STARVE_LIMIT = 8;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_DATA_W-1:0] fb_data_t;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnHost = 2'd1,
    OwnDisp = 2'd2
  } owner_e;

endpackage : vga_fb_pkg

// File: rtl/vga_fb_rd_tag_pipe.sv
// ----------------------------------------------------------------------------
// vga_fb_rd_tag_pipe
// Two-deep owner tag shift register. Stage 0 lines up with the registered RAM
// command, stage 1 lines up with the RAM read data, so the decoded rvalid
// strobes are high for exactly the one cycle the returning word is on the bus.
// Ports:
//   clk            clock
//   arst_n         synchronous active-low reset (clears both stages)
//   own_i          owner of the read accepted this cycle (OwnNone if none)
//   host_rvalid_o  read data on mem_rdata belongs to the host
//   disp_rvalid_o  read data on mem_rdata belongs to the display
// ----------------------------------------------------------------------------
module vga_fb_rd_tag_pipe
  import vga_fb_pkg::*;
(
  input  logic   clk,
  input  logic   arst_n,
  input  owner_e own_i,
  output logic   host_rvalid_o,
  output logic   disp_rvalid_o
);

  owner_e tag0_q, tag0_d;
  owner_e tag1_q, tag1_d;

  always_comb begin
    tag0_d = own_i;
    tag1_d = tag0_q;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      tag0_q <= OwnNone;
      tag1_q <= OwnNone;
    end else begin
      tag0_q <= tag0_d;
      tag1_q <= tag1_d;
    end
  end

  assign host_rvalid_o = (tag1_q == OwnHost);
  assign disp_rvalid_o = (tag1_q == OwnDisp);

endmodule : vga_fb_rd_tag_pipe

// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between a read/write host
// port and a read-only display port. The display has fixed priority; a wait
// counter forces a host grant after STARVE_LIMIT consecutive host denials.
// The RAM command is registered and read data is tagged with its owner.
//
// Ports:
//   clk, arst_n                  clock, synchronous active-low reset
//   host_req_i/we_i/addr_i/wdata_i  host request (held until granted)
//   host_gnt_o                   host transfer accepted this cycle
//   host_rvalid_o/host_rdata_o   host read return (2 cycles after grant)
//   disp_req_i/disp_addr_i       display read request (held until granted)
//   disp_gnt_o                   display transfer accepted this cycle
//   disp_rvalid_o/disp_rdata_o   display read return (2 cycles after grant)
//   mem_en_o/we_o/addr_o/wdata_o registered RAM command
//   mem_rdata_i                  RAM read data, 1 cycle after mem_en_o
//
// Optional build macro VGA_FB_ARB_STATS_EN adds:
//   stats_clr_i                  synchronous clear of both counters
//   host_grant_cnt_o             number of host grants (wraps at 2^32)
//   host_stall_cnt_o             cycles with host_req_i && !host_gnt_o
// ----------------------------------------------------------------------------
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned DATA_W       = FB_DATA_W,
  parameter int unsigned STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_gnt_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
`ifdef VGA_FB_ARB_STATS_EN
  input  logic              stats_clr_i,
  output logic [31:0]       host_grant_cnt_o,
  output logic [31:0]       host_stall_cnt_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              host_forced;
  logic              host_gnt, disp_gnt;
  owner_e            rd_own;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // --------------------------------------------------------------------------
  // Grant: display wins unless the host has been denied STARVE_LIMIT times in
  // a row, in which case the host takes this one slot.
  // --------------------------------------------------------------------------
  always_comb begin
    host_forced = host_req_i && (wait_cnt_q == WAIT_MAX);
    disp_gnt    = disp_req_i && !host_forced;
    host_gnt    = host_req_i && !disp_gnt;
  end

  // Counts consecutive denied host cycles; saturation is defensive, the
  // forced grant already clears it on reaching WAIT_MAX.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!host_req_i || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Command stage. Address follows the winner; write data is only loaded on
  // a host write so the RAM data bus stays quiet during reads.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en_d    = host_gnt || disp_gnt;
    mem_we_d    = host_gnt && host_we_i;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_gnt) begin
      mem_addr_d = disp_addr_i;
    end else if (host_gnt) begin
      mem_addr_d = host_addr_i;
      if (host_we_i) begin
        mem_wdata_d = host_wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read owner tagging. Host writes carry no tag so they never raise rvalid.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_own = OwnNone;
    if (disp_gnt) begin
      rd_own = OwnDisp;
    end else if (host_gnt && !host_we_i) begin
      rd_own = OwnHost;
    end
  end

  vga_fb_rd_tag_pipe u_tag_pipe (
    .clk           (clk),
    .arst_n        (arst_n),
    .own_i         (rd_own),
    .host_rvalid_o (host_rvalid_o),
    .disp_rvalid_o (disp_rvalid_o)
  );

`ifdef VGA_FB_ARB_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr_i) begin
      grant_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (host_gnt) begin
        grant_cnt_d = grant_cnt_q + 32'd1;
      end
      if (host_req_i && !host_gnt) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign host_grant_cnt_o = grant_cnt_q;
  assign host_stall_cnt_o = stall_cnt_q;
`endif

  assign host_gnt_o   = host_gnt;
  assign disp_gnt_o   = disp_gnt;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  // Both read ports see the raw RAM bus; rvalid says whose word it is.
  assign host_rdata_o = mem_rdata_i;
  assign disp_rdata_o = mem_rdata_i;

endmodule : vga_fb_arbiter

// File: tb/tb_vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
// Build with VGA_FB_ARB_STATS_EN defined to also exercise the host counters.
// ----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_gnt, disp_rvalid;
  logic [31:0] disp_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
`ifdef VGA_FB_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] grant_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_gnt_o    (host_gnt),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .disp_req_i    (disp_req),
    .disp_addr_i   (disp_addr),
    .disp_gnt_o    (disp_gnt),
    .disp_rvalid_o (disp_rvalid),
    .disp_rdata_o  (disp_rdata),
`ifdef VGA_FB_ARB_STATS_EN
    .stats_clr_i      (stats_clr),
    .host_grant_cnt_o (grant_cnt),
    .host_stall_cnt_o (stall_cnt),
`endif
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  // Single-port synchronous RAM, read data one cycle after enable.
  logic [31:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h @%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_drive(input logic req, input logic we, input logic [15:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic disp_drive(input logic req, input logic [15:0] a);
    disp_req = req; disp_addr = a;
  endtask

  initial begin
    logic exp_h;
    int   exp_own; // 0 none, 1 host, 2 disp

    arst_n = 1'b0;
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
    disp_drive(1'b0, 16'h0);
`ifdef VGA_FB_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    arst_n = 1'b1;
    #1;
    chk("rst_mem_en",      32'(mem_en),      32'd0);
    chk("rst_mem_we",      32'(mem_we),      32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",   mem_wdata,        32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("idle_host_gnt",   32'(host_gnt),    32'd0);
    chk("idle_disp_gnt",   32'(disp_gnt),    32'd0);
    tick();

    // ---- 1: host write then read-after-write to 0x0010 ----
    host_drive(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    #1;
    chk("t1_wr_gnt", 32'(host_gnt), 32'd1);
    tick();
    chk("t1_wr_mem_en",    32'(mem_en),   32'd1);
    chk("t1_wr_mem_we",    32'(mem_we),   32'd1);
    chk("t1_wr_mem_addr",  32'(mem_addr), 32'h0010);
    chk("t1_wr_mem_wdata", mem_wdata,     32'hDEADBEEF);
    host_drive(1'b1, 1'b0, 16'h0010, 32'h0);
    #1;
    chk("t1_rd_gnt", 32'(host_gnt), 32'd1);
    tick();
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t1_rd_mem_we",      32'(mem_we),      32'd0);
    chk("t1_wr_no_rvalid",   32'(host_rvalid), 32'd0);
    tick();
    chk("t1_rd_rvalid",      32'(host_rvalid), 32'd1);
    chk("t1_rd_rdata",       host_rdata,       32'hDEADBEEF);
    chk("t1_disp_rvalid",    32'(disp_rvalid), 32'd0);
    tick();
    chk("t1_rvalid_1cyc",    32'(host_rvalid), 32'd0);
    chk("t1_idle_mem_en",    32'(mem_en),      32'd0);

    // Preload words used later: 0x0100 = 0xA, 0x0200 = 0xB (back-to-back writes)
    host_drive(1'b1, 1'b1, 16'h0100, 32'h0000000A);
    tick();
    host_drive(1'b1, 1'b1, 16'h0200, 32'h0000000B);
    tick();
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
`ifdef VGA_FB_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`else
    tick();
`endif

    // ---- 2/3: both requesting continuously, host wins every 9th cycle ----
    host_drive(1'b1, 1'b0, 16'h0200, 32'h0);
    disp_drive(1'b1, 16'h0100);
    for (int c = 1; c <= 18; c++) begin
      #1;
      exp_h = (c % 9 == 0);
      chk($sformatf("t3_host_gnt_c%0d", c), 32'(host_gnt), 32'(exp_h));
      chk($sformatf("t3_disp_gnt_c%0d", c), 32'(disp_gnt), 32'(!exp_h));
      tick();
      chk($sformatf("t3_mem_addr_c%0d", c), 32'(mem_addr), exp_h ? 32'h0200 : 32'h0100);
    end
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
    disp_drive(1'b0, 16'h0);
`ifdef VGA_FB_ARB_STATS_EN
    chk("t6_grant_cnt", grant_cnt, 32'd2);
    chk("t6_stall_cnt", stall_cnt, 32'd16);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("t6_grant_clr", grant_cnt, 32'd0);
    chk("t6_stall_clr", stall_cnt, 32'd0);
`endif
    tick(); tick(); tick();

    // ---- 4: alternating disp 0x0100 / host 0x0200 reads ----
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        if (i % 2 == 0) begin
          disp_drive(1'b1, 16'h0100);
          host_drive(1'b0, 1'b0, 16'h0, 32'h0);
        end else begin
          disp_drive(1'b0, 16'h0);
          host_drive(1'b1, 1'b0, 16'h0200, 32'h0);
        end
      end else begin
        disp_drive(1'b0, 16'h0);
        host_drive(1'b0, 1'b0, 16'h0, 32'h0);
      end
      #1;
      if (i < 6) begin
        chk($sformatf("t4_disp_gnt_i%0d", i), 32'(disp_gnt), 32'(i % 2 == 0));
        chk($sformatf("t4_host_gnt_i%0d", i), 32'(host_gnt), 32'(i % 2 == 1));
      end
      exp_own = 0;
      if (i >= 2 && i - 2 < 6) exp_own = ((i - 2) % 2 == 0) ? 2 : 1;
      chk($sformatf("t4_disp_rvalid_i%0d", i), 32'(disp_rvalid), 32'(exp_own == 2));
      chk($sformatf("t4_host_rvalid_i%0d", i), 32'(host_rvalid), 32'(exp_own == 1));
      if (exp_own == 2) chk($sformatf("t4_disp_rdata_i%0d", i), disp_rdata, 32'h0000000A);
      if (exp_own == 1) chk($sformatf("t4_host_rdata_i%0d", i), host_rdata, 32'h0000000B);
      tick();
    end

    // ---- 5: reset with two display reads in flight and wait count raised ----
    host_drive(1'b1, 1'b0, 16'h0200, 32'h0);
    disp_drive(1'b1, 16'h0100);
    #1;
    chk("t5_pre_disp_gnt0", 32'(disp_gnt), 32'd1);
    tick();
    #1;
    chk("t5_pre_disp_gnt1", 32'(disp_gnt), 32'd1);
    tick();
    arst_n = 1'b0;
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
    disp_drive(1'b0, 16'h0);
    tick();
    arst_n = 1'b1;
    chk("t5_mem_en",   32'(mem_en),   32'd0);
    chk("t5_mem_we",   32'(mem_we),   32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    // Wait count must restart from zero: host again waits a full 9 cycles.
    host_drive(1'b1, 1'b0, 16'h0200, 32'h0);
    disp_drive(1'b1, 16'h0100);
    for (int k = 0; k < 9; k++) begin
      #1;
      if (k < 2) begin
        chk($sformatf("t5_disp_rvalid_k%0d", k), 32'(disp_rvalid), 32'd0);
        chk($sformatf("t5_host_rvalid_k%0d", k), 32'(host_rvalid), 32'd0);
      end
      chk($sformatf("t5_host_gnt_k%0d", k), 32'(host_gnt), 32'(k == 8));
      tick();
    end
    host_drive(1'b0, 1'b0, 16'h0, 32'h0);
    disp_drive(1'b0, 16'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_fb_arbiter
